knn_sample_feeder: RTL
======================

KNN_SAMPLE_FEEDER -- requirements
Module: knn_sample_feeder

Interface
REQ-001 SHALL have parameter FEATURE_WIDE, default 4: bits per feature.
REQ-002 SHALL have parameter FEATURE_NUM, default 4: features per sample; WIDE = FEATURE_NUM*FEATURE_WIDE.
REQ-003 SHALL have parameter DATA_WIDE, default 3: label bits.
REQ-004 SHALL have parameter COM_NUM, default 600: samples per pass, range 2..2048.
REQ-005 SHALL have parameter ADDR_W, default 11: sample memory address width.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port start, input, 1: begin a pass; sampled only in IDLE.
REQ-009 SHALL have port stop, input, 1: abort the current pass or loop.
REQ-010 SHALL have port query_feature, input, WIDE: query vector, latched on start acceptance.
REQ-011 SHALL have port mem_rd_en, output, 1: sample memory read strobe.
REQ-012 SHALL have port mem_addr, output, ADDR_W: sample index to read.
REQ-013 SHALL have port mem_rdata, input, WIDE+DATA_WIDE: {label, features}, valid exactly 1 cycle after mem_rd_en.
REQ-014 SHALL have port feature, output, WIDE: latched query vector.
REQ-015 SHALL have port train_data, output, WIDE+DATA_WIDE: current sample.
REQ-016 SHALL have port out_valid, output, 1: train_data is valid.
REQ-017 SHALL have port out_ready, input, 1: consumer accepts the sample when both out_valid and out_ready are 1.
REQ-018 SHALL have port out_last, output, 1: marks sample index COM_NUM-1.
REQ-019 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-020 SHALL have port done, output, 1: one-cycle pulse when a pass completes.

Function
REQ-021 SHALL implement FSM states IDLE, FETCH, DRAIN. Transitions:
- IDLE->FETCH on start.
- FETCH->DRAIN after the read of index COM_NUM-1 is issued.
- DRAIN->IDLE on acceptance of the out_last sample.
REQ-022 SHALL, on start acceptance, capture query_feature into feature and reset the read index to 0; feature SHALL hold constant until the next start acceptance.
REQ-023 SHALL buffer read data in a 4-entry FIFO driving train_data, out_valid and out_last.
REQ-024 SHALL issue a read in FETCH only when FIFO occupancy + in-flight reads - (pop this cycle) < 4.
REQ-025 SHALL increment mem_addr by 1 per issued read, never exceeding COM_NUM-1.
REQ-026 SHALL, with out_ready held 1, assert out_valid for index 0 on the 3rd rising edge after the edge that samples start, then deliver one sample per cycle with no gaps.
REQ-027 SHALL hold train_data and out_last stable while out_valid=1 and out_ready=0, issuing no reads beyond the FIFO credit.
REQ-028 SHALL deliver samples in index order 0..COM_NUM-1, with no loss or duplication under any out_ready pattern.
REQ-029 SHALL pulse done in the cycle after the out_last sample is accepted.
REQ-030 SHALL ignore start while busy=1.
REQ-031 SHALL, on stop=1 in FETCH or DRAIN:
- flush the FIFO and discard any in-flight read;
- drive out_valid=0 and enter IDLE on the next edge;
- not pulse done.
stop in IDLE SHALL have no effect.
REQ-032 SHALL give stop priority when start and stop are both 1 in IDLE: no pass starts.
REQ-033 SHALL drive mem_rd_en=0 in IDLE and DRAIN.

Reset
REQ-034 SHALL, while rst=1, asynchronously force:
- state to IDLE and clear the FIFO;
- mem_rd_en, out_valid, out_last, busy and done to 0;
- mem_addr, feature and train_data to 0.
REQ-035 SHALL, if reset arrives mid-pass, abandon the pass; no done follows reset release.

Configuration
REQ-036 SHALL support macro KNN_FEEDER_LOOP_EN:
- When defined: after accepting out_last, the FSM SHALL re-enter FETCH from index 0 on the next edge, keeping feature, busy=1 and pulsing done once per pass, and SHALL repeat until stop.
- When undefined: the FSM SHALL return to IDLE after each pass.

Verification
REQ-037 SHALL cover: COM_NUM=4, out_ready=1, start -> out_valid on 3rd edge, indices 0,1,2,3 on consecutive cycles, out_last with index 3, done 1 cycle later, busy=0.
REQ-038 SHALL cover: out_ready toggling 1,0,0,1 repeatedly over 600 samples -> all 600 samples delivered in order, data stable while stalled, mem_rd_en never exceeding credit.
REQ-039 SHALL cover: stop at the 10th accepted sample -> out_valid=0 next cycle, IDLE, no done, next start restarts at index 0 with the new query_feature.
REQ-040 SHALL cover: start during busy, and start+stop together in IDLE -> both ignored.
REQ-041 SHALL cover: rst pulse mid-DRAIN -> all outputs 0 immediately, no done after release.
REQ-042 SHALL cover: KNN_FEEDER_LOOP_EN defined, COM_NUM=4 -> index sequence 0..3,0..3 with gapless looping, done pulsing each pass, stop ending the loop.

Source files
------------

// File: rtl/knn_sample_feeder.sv
// Streams COM_NUM stored samples into a 4-entry FIFO for a KNN distance engine.
// Optional KNN_FEEDER_LOOP_EN: restart the pass forever, without gaps, until stop.
module knn_sample_feeder #(
    parameter int FEATURE_WIDE = 4,
    parameter int FEATURE_NUM  = 4,
    parameter int DATA_WIDE    = 3,
    parameter int COM_NUM      = 600,
    parameter int ADDR_W       = 11
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      stop,
    input  logic [FEATURE_NUM*FEATURE_WIDE-1:0]       query_feature,
    output logic                                      mem_rd_en,
    output logic [ADDR_W-1:0]                         mem_addr,
    input  logic [FEATURE_NUM*FEATURE_WIDE+DATA_WIDE-1:0] mem_rdata,
    output logic [FEATURE_NUM*FEATURE_WIDE-1:0]       feature,
    output logic [FEATURE_NUM*FEATURE_WIDE+DATA_WIDE-1:0] train_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      out_last,
    output logic                                      busy,
    output logic                                      done
);

    localparam int WIDE = FEATURE_NUM * FEATURE_WIDE;
    localparam int TW   = WIDE + DATA_WIDE;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(COM_NUM - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic              start_acc, flush, issue, last_issue, pop, push, accept_last;
    logic [3:0]        occ_sum;
    logic              credit_ok;

    logic              vld_p0, last_p0;
    logic              vld_p1, last_p1;
    logic [TW-1:0]     data_p1;

    logic [TW-1:0]     fifo_data [4];
    logic [3:0]        fifo_last;
    logic [1:0]        wr_ptr, rd_ptr;
    logic [2:0]        count;

    assign start_acc   = (state == IDLE) && start && !stop;
    assign flush       = stop && (state != IDLE);
    assign out_valid   = (count != 3'd0);
    assign pop         = out_valid && out_ready;
    assign push        = vld_p1 && !flush;
    assign out_last    = out_valid && fifo_last[rd_ptr];
    assign train_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign accept_last = pop && out_last;
    assign busy        = (state != IDLE);

    // Everything already committed (FIFO + both read-pipeline slots) counts against the 4 slots.
    assign occ_sum     = {1'b0, count} + {3'b0, vld_p0} + {3'b0, vld_p1} - {3'b0, pop};
    assign credit_ok   = (occ_sum < 4'd4);
    assign issue       = (state == FETCH) && !stop && credit_ok;
    assign last_issue  = issue && (idx == LAST_IDX);
    assign mem_rd_en   = issue;
    assign mem_addr    = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_acc) state_nxt = FETCH;
            FETCH: begin
                if (stop) state_nxt = IDLE;
`ifndef KNN_FEEDER_LOOP_EN
                else if (last_issue) state_nxt = DRAIN;
`endif
            end
            DRAIN: if (stop || accept_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            feature <= '0;
            done    <= 1'b0;
        end else begin
            done <= accept_last && !flush;
            if (start_acc) begin
                idx     <= '0;
                feature <= query_feature;
            end else if (issue) begin
                if (idx == LAST_IDX) begin
`ifdef KNN_FEEDER_LOOP_EN
                    idx <= '0;
`else
                    idx <= idx;
`endif
                end else begin
                    idx <= idx + ADDR_W'(1);
                end
            end
        end
    end

    // Stage p0: read issued, memory data on the bus next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p0  <= issue;
            last_p0 <= last_issue;
            vld_p1  <= vld_p0 && !flush;
            last_p1 <= last_p0;
        end
    end

    // Stage p1: bus data registered before entering the FIFO
    always_ff @(posedge clk) begin
        data_p1 <= mem_rdata;
        if (push) fifo_data[wr_ptr] <= data_p1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_last <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_last[wr_ptr] <= last_p1;
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b0, push} - {2'b0, pop};
        end
    end

endmodule
